// File: rtl/sib_cdc_req_tx.sv
// Source-side launcher for a toggle-handshake CDC: holds a word on xfer_data and toggles xfer_req.
// Latency: launch visible one cycle after acceptance; done pulses the cycle after the matching ack.
// Backpressure: in_ready drops while the one-entry pending buffer is full.
module sib_cdc_req_tx #(
    parameter int DATA_W     = 32,
    parameter int ACK_TO_CYC = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              ack_sync,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TO_CYC);

    state_t              state;
    logic                pendVld;
    logic [DATA_W-1:0]   pendData;
    logic [CNT_W-1:0]    waitCnt;

    logic                complete;
    logic                launch;
    logic                takePend;
    logic                capture;
    logic                goIdle;
    logic [DATA_W-1:0]   launchData;

    // Pending slot is the only thing that can refuse a word.
    assign in_ready = ~pendVld;
    assign busy     = (state == WAIT_ACK);
    // The ack toggle only means anything while a word is outstanding.
    assign complete = (state == WAIT_ACK) && (ack_sync == xfer_req);

    // Decide this cycle's action: launch (from pending or bypass), park in pending, or fall idle.
    always_comb begin
        launch     = 1'b0;
        takePend   = 1'b0;
        capture    = 1'b0;
        goIdle     = 1'b0;
        launchData = in_data;
        case (state)
            IDLE: begin
                if (pendVld) begin
                    launch     = 1'b1;
                    takePend   = 1'b1;
                    launchData = pendData;
                end else if (in_valid) begin
                    launch = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (complete) begin
                    if (pendVld) begin
                        launch     = 1'b1;
                        takePend   = 1'b1;
                        launchData = pendData;
                    end else if (in_valid) begin
                        launch = 1'b1;
                    end else begin
                        goIdle = 1'b1;
                    end
                end else begin
                    capture = in_valid & in_ready;
                end
            end
            default: goIdle = 1'b1;
        endcase
    end

    // Sequential state: active/pending words, handshake FSM, wait counter and sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            xfer_req    <= 1'b0;
            xfer_data   <= '0;
            pendVld     <= 1'b0;
            pendData    <= '0;
            waitCnt     <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done <= complete;
            if (launch) begin
                xfer_data <= launchData;
                xfer_req  <= ~xfer_req;
                waitCnt   <= '0;
                state     <= WAIT_ACK;
            end else if (goIdle) begin
                state <= IDLE;
            end else if (state == WAIT_ACK && waitCnt != '1) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (takePend) begin
                pendVld <= 1'b0;
            end else if (capture) begin
                pendVld  <= 1'b1;
                pendData <= in_data;
            end
            // Timeout only flags; the transfer keeps waiting for its ack.
            if (ACK_TO_CYC != 0 && waitCnt == TIMEOUT_VAL) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule
